// File: rtl/plab4_net_inject_adapter_if.sv
// Terminal-side and router-side handshake bundle for the inject adapter.
// master drives terminal messages and router ready; slave is the adapter.
interface plab4_net_inject_adapter_if #(
    parameter int p_num_routers   = 8,
    parameter int p_payload_nbits = 32,
    parameter int p_opaque_nbits  = 8
);
    localparam int c_dest_nbits = $clog2(p_num_routers);
    localparam int c_msg_nbits  =
        2*c_dest_nbits + p_opaque_nbits + p_payload_nbits;

    logic                       in_val;
    logic                       in_rdy;
    logic [c_dest_nbits-1:0]    in_dest;
    logic [p_payload_nbits-1:0] in_payload;
    logic                       in_sd;
    logic                       out_val;
    logic                       out_rdy;
    logic [c_msg_nbits-1:0]     out_msg;
    logic                       out_sd;

    modport master (
        output in_val, in_dest, in_payload, in_sd, out_rdy,
        input  in_rdy, out_val, out_msg, out_sd
    );

    modport slave (
        input  in_val, in_dest, in_payload, in_sd, out_rdy,
        output in_rdy, out_val, out_msg, out_sd
    );
endinterface

// File: rtl/plab4_net_inject_adapter.sv
// Source-side ring adapter: stamps src and per-domain opaque tags,
// buffers two packets and injects them into the router terminal input.
module plab4_net_inject_adapter #(
    parameter int p_router_id     = 0,
    parameter int p_num_routers   = 8,
    parameter int p_payload_nbits = 32,
    parameter int p_opaque_nbits  = 8
) (
    input logic clk,
    input logic reset,
    plab4_net_inject_adapter_if.slave io
);
    localparam int c_dest_nbits = $clog2(p_num_routers);
    localparam int c_msg_nbits  =
        2*c_dest_nbits + p_opaque_nbits + p_payload_nbits;
    localparam logic [c_dest_nbits-1:0] c_src =
        c_dest_nbits'(p_router_id);

    logic [c_msg_nbits-1:0]    data [2];
    logic [1:0]                sds;
    logic [p_opaque_nbits-1:0] opq [2];
    logic                      head;
    logic                      tail;
    logic [1:0]                count;
    logic                      live;
    logic                      enq;
    logic                      deq;

    // live keeps in_rdy low until the first edge after reset release
    assign io.in_rdy  = live && (count != 2'd2);
    assign io.out_val = (count != 2'd0);
    assign io.out_msg = io.out_val ? data[head] : '0;
    assign io.out_sd  = io.out_val & sds[head];

    assign enq = io.in_val && io.in_rdy;
    assign deq = io.out_val && io.out_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= '{default: '0};
            sds   <= '0;
            opq   <= '{default: '0};
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (enq) begin
                data[tail] <= {io.in_dest, c_src,
                               opq[io.in_sd], io.in_payload};
                sds[tail]  <= io.in_sd;
                tail       <= tail + 1'b1;
                opq[io.in_sd] <= opq[io.in_sd] + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule
